// File: rtl/fw_interface_ctrl_pkg.sv
// Shared definitions for the firmware interface controller: message class
// codes, FSM state encoding and string memory geometry.
package fw_interface_ctrl_pkg;

  localparam int STR_IDX_W = 6;
  localparam int STR_DEPTH = 1 << STR_IDX_W;
  localparam int MSG_VAL_W = 32;

  localparam logic [1:0] CLS_NONE    = 2'b00;
  localparam logic [1:0] CLS_REPORT  = 2'b01;
  localparam logic [1:0] CLS_WARNING = 2'b10;
  localparam logic [1:0] CLS_ERROR   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_SEND = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/fw_interface_ctrl_slot.sv
// One pending-message slot: holds a captured value until the arbiter takes
// it, and remembers (sticky) whether any strobe arrived while still full.
module fw_interface_ctrl_slot #(
  parameter int MSG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture,
  input  logic [MSG_W-1:0] capture_value,
  input  logic             clear,
  output logic [MSG_W-1:0] value,
  output logic             pending,
  output logic             lost
);

  // Capture into a free slot (or one being freed this cycle); drop and flag otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value   <= '0;
      pending <= 1'b0;
      lost    <= 1'b0;
    end else begin
      if (capture && (!pending || clear)) begin
        value   <= capture_value;
        pending <= 1'b1;
      end else if (clear) begin
        pending <= 1'b0;
      end
      if (capture && pending && !clear) begin
        lost <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fw_interface_ctrl.sv
// Firmware interface controller: buffers one report/warning/error each,
// collects a character stream into string memory, and dispatches messages
// in error > warning > report order over a valid/ready port.
module fw_interface_ctrl
  import fw_interface_ctrl_pkg::*;
#(
  parameter int MSG_W = MSG_VAL_W,
  parameter int IDX_W = STR_IDX_W
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             new_report,
  input  logic             new_warning,
  input  logic             new_error,
  input  logic [MSG_W-1:0] report_reg,
  input  logic [MSG_W-1:0] warning_reg,
  input  logic [MSG_W-1:0] error_reg,
  input  logic             char_valid,
  input  logic [7:0]       char_data,
  output logic             char_ready,
  output logic [IDX_W-1:0] index,
  output logic [7:0]       data,
  output logic             write_mem,
  output logic             msg_valid,
  input  logic             msg_ready,
  output logic [1:0]       msg_class,
  output logic [MSG_W-1:0] msg_value,
  output logic [IDX_W:0]   msg_len,
  output logic [2:0]       lost
);

  localparam logic [IDX_W:0] DEPTH = {1'b1, {IDX_W{1'b0}}};

  fsm_state_t       state;
  logic [IDX_W:0]   count;

  logic             rep_pend, warn_pend, err_pend;
  logic             rep_lost, warn_lost, err_lost;
  logic [MSG_W-1:0] rep_val, warn_val, err_val;
  logic             rep_clr, warn_clr, err_clr;

  logic [1:0]       sel_cls;
  logic [MSG_W-1:0] sel_val;

  fw_interface_ctrl_slot #(.MSG_W(MSG_W)) u_report_slot (
    .clk(wb_clk_i), .rst_n(wb_rst_i), .capture(new_report), .capture_value(report_reg),
    .clear(rep_clr), .value(rep_val), .pending(rep_pend), .lost(rep_lost)
  );

  fw_interface_ctrl_slot #(.MSG_W(MSG_W)) u_warning_slot (
    .clk(wb_clk_i), .rst_n(wb_rst_i), .capture(new_warning), .capture_value(warning_reg),
    .clear(warn_clr), .value(warn_val), .pending(warn_pend), .lost(warn_lost)
  );

  fw_interface_ctrl_slot #(.MSG_W(MSG_W)) u_error_slot (
    .clk(wb_clk_i), .rst_n(wb_rst_i), .capture(new_error), .capture_value(error_reg),
    .clear(err_clr), .value(err_val), .pending(err_pend), .lost(err_lost)
  );

  assign lost = {err_lost, warn_lost, rep_lost};

  // Characters are only taken while idle and the string memory still has room
  assign char_ready = (state == ST_IDLE) && (count < DEPTH);
  assign write_mem  = char_valid && char_ready;
  assign index      = count[IDX_W-1:0];
  assign data       = char_data;

  // Fixed-priority pick of the highest pending class
  always_comb begin
    sel_cls = CLS_NONE;
    sel_val = '0;
    if (err_pend) begin
      sel_cls = CLS_ERROR;
      sel_val = err_val;
    end else if (warn_pend) begin
      sel_cls = CLS_WARNING;
      sel_val = warn_val;
    end else if (rep_pend) begin
      sel_cls = CLS_REPORT;
      sel_val = rep_val;
    end
  end

  assign err_clr  = (state == ST_ARB) && (sel_cls == CLS_ERROR);
  assign warn_clr = (state == ST_ARB) && (sel_cls == CLS_WARNING);
  assign rep_clr  = (state == ST_ARB) && (sel_cls == CLS_REPORT);

  // Dispatch FSM with character counter and registered message outputs
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state     <= ST_IDLE;
      count     <= '0;
      msg_valid <= 1'b0;
      msg_class <= CLS_NONE;
      msg_value <= '0;
      msg_len   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (write_mem) begin
            count <= count + 1'b1;
          end
          if (err_pend || warn_pend || rep_pend) begin
            state <= ST_ARB;
          end
        end
        ST_ARB: begin
          msg_class <= sel_cls;
          msg_value <= sel_val;
          msg_len   <= count;
          msg_valid <= 1'b1;
          state     <= ST_SEND;
        end
        ST_SEND: begin
          if (msg_ready) begin
            msg_valid <= 1'b0;
            count     <= '0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
